match_event_counter: RTL and testbench
======================================

Name: match_event_counter

Overview:
- Downstream consumer of the serial 1010 Moore detector's single-bit match output.
- Counts match events as rising edges of the detector output and holds the count as two BCD digits.
- Drives two active-low seven-segment displays, a pulse-stretched hit LED and a sticky overflow flag for the lab board.
- Clocked on the same clk as the detector; no clock-domain crossing.

Parameters:
- STRETCH_CYCLES, 4, number of cycles hit_led stays high after each counted event (legal range 1..15).
- WRAP, 1, overflow policy at 99: 1 wraps to 00, 0 saturates at 99.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous clear of count, overflow and stretch
- enable  input  1  counting enable; when low, events are ignored
- det_in  input  1  match output from the 1010 detector
- count_ones  output  4  BCD ones digit (0..9)
- count_tens  output  4  BCD tens digit (0..9)
- hex0  output  7  active-low segments {g,f,e,d,c,b,a} for count_ones
- hex1  output  7  active-low segments for count_tens; blanked when tens = 0
- hit_led  output  1  stretched event indicator
- overflow  output  1  sticky; set on the first event seen at count 99

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - While reset is high: count_ones = 0, count_tens = 0, overflow = 0, hit_led = 0, stretch counter = 0, edge FSM in WAIT_HIGH.
  - hex0 = 7'b1000000 and hex1 = 7'b1111111.
  - Reset may assert at any time, including mid-stretch or mid-event, and takes effect immediately.
- Edge FSM, two states:
  - WAIT_HIGH:
    - det_in = 1 -> ARMED, and an event fires this cycle.
    - det_in = 0 -> stay in WAIT_HIGH.
  - ARMED:
    - det_in = 0 -> WAIT_HIGH.
    - det_in = 1 -> stay in ARMED, no further event.
  - The FSM advances regardless of enable or clear.
  - A det_in held high for N cycles counts once.
- Event qualification: event = (state == WAIT_HIGH) & det_in & enable & ~clear.
- Count update happens at the same rising edge at which the event is sampled; new values are visible right after that edge (latency 1 edge).
  - ones < 9: ones += 1.
  - ones = 9 and tens < 9: ones = 0, tens += 1.
  - count = 99, WRAP = 1: count -> 00, overflow -> 1.
  - count = 99, WRAP = 0: count holds 99, overflow -> 1.
- overflow stays at 1 until clear or reset.
- Stretch counter (4-bit):
  - An event loads STRETCH_CYCLES, restarting any count in progress.
  - Otherwise it decrements when nonzero.
  - hit_led = (stretch counter != 0), so hit_led is high for exactly STRETCH_CYCLES cycles after an isolated event.
- clear (synchronous) has priority over an event in the same cycle:
  - Zeroes count, overflow and stretch; event is suppressed.
  - The edge FSM still tracks det_in, so a det_in high during clear is not counted later.
- Seven-segment decode is combinational from the count registers, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any non-BCD value displays 1111111 (unreachable in normal operation).
- Back-to-back detector matches arrive at least 2 cycles apart (1-0 pattern on det_in), so every match is counted.

Test Plan:
- Reset, then det_in pulses 3 times (1 cycle high, 3 low each), enable = 1 -> ones = 3, tens = 0, hex0 = 0110000, hex1 = 1111111.
- det_in held high 10 cycles -> count increments by exactly 1; hit_led high for exactly 4 cycles, then low.
- 99 events with WRAP = 1, then 1 more -> count 00, overflow = 1; with WRAP = 0 -> count stays 99, overflow = 1; a further event leaves both unchanged.
- enable = 0 during 5 pulses, then enable = 1 for 2 pulses -> count = 02; clear asserted in the same cycle as a rising det_in -> count = 00, overflow = 0, hit_led = 0, and no later increment from that pulse.
- Two events 2 cycles apart -> stretch reloads on the second event; hit_led stays high for 2 + 4 cycles continuously; count = 12 shows hex1 = 1111001, hex0 = 0100100.
- Asynchronous reset asserted mid-stretch, between clock edges, at count 47 -> all outputs at reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/match_event_counter.sv
// Counts rising edges of the 1010 detector's match output as two BCD digits and
// drives the lab board's seven-segment displays, a stretched hit LED and an overflow flag.
module match_event_counter #(
  parameter int unsigned STRETCH_CYCLES = 4,
  parameter bit          WRAP           = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       det_in,
  output logic [3:0] count_ones,
  output logic [3:0] count_tens,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic       hit_led,
  output logic       overflow
);

  localparam logic [0:0] WAIT_HIGH = 1'b0;
  localparam logic [0:0] ARMED     = 1'b1;

  localparam logic [3:0] STRETCH_LOAD = 4'(STRETCH_CYCLES);
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [6:0] SEG_BLANK    = 7'b1111111;

  logic [0:0] state;
  logic [0:0] state_next;
  logic       event_fire;

  logic [3:0] ones_next;
  logic [3:0] tens_next;
  logic       overflow_next;
  logic [3:0] stretch_cnt;
  logic [3:0] stretch_next;

  // Edge detector tracks det_in unconditionally, so a level held high through
  // clear or enable=0 is never counted once those are released.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_HIGH: if (det_in)  state_next = ARMED;
      ARMED:     if (!det_in) state_next = WAIT_HIGH;
      default:   state_next = WAIT_HIGH;
    endcase
  end

  assign event_fire = (state == WAIT_HIGH) & det_in & enable & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_HIGH;
    else       state <= state_next;
  end

  always_comb begin
    ones_next     = count_ones;
    tens_next     = count_tens;
    overflow_next = overflow;
    if (clear) begin
      ones_next     = 4'd0;
      tens_next     = 4'd0;
      overflow_next = 1'b0;
    end else if (event_fire) begin
      if (count_ones != BCD_MAX) begin
        ones_next = count_ones + 4'd1;
      end else if (count_tens != BCD_MAX) begin
        ones_next = 4'd0;
        tens_next = count_tens + 4'd1;
      end else begin
        // At 99 the flag is set either way; WRAP only decides whether we roll to 00.
        overflow_next = 1'b1;
        if (WRAP) begin
          ones_next = 4'd0;
          tens_next = 4'd0;
        end
      end
    end
  end

  always_comb begin
    stretch_next = stretch_cnt;
    if (clear)                   stretch_next = 4'd0;
    else if (event_fire)         stretch_next = STRETCH_LOAD;
    else if (stretch_cnt != 4'd0) stretch_next = stretch_cnt - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_ones  <= 4'd0;
      count_tens  <= 4'd0;
      overflow    <= 1'b0;
      stretch_cnt <= 4'd0;
    end else begin
      count_ones  <= ones_next;
      count_tens  <= tens_next;
      overflow    <= overflow_next;
      stretch_cnt <= stretch_next;
    end
  end

  assign hit_led = (stretch_cnt != 4'd0);

  // Active-low segment order is {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  assign hex0 = seg7(count_ones);
  assign hex1 = (count_tens == 4'd0) ? SEG_BLANK : seg7(count_tens);

endmodule

// File: tb/tb_match_event_counter.sv
// Directed bench for match_event_counter: one wrapping and one saturating instance
// driven from the same stimulus, checked against hand-computed values.
module tb_match_event_counter;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       enable;
  logic       det_in;

  logic [3:0] count_ones, count_tens;
  logic [6:0] hex0, hex1;
  logic       hit_led, overflow;

  logic [3:0] sat_ones, sat_tens;
  logic [6:0] sat_hex0, sat_hex1;
  logic       sat_hit_led, sat_overflow;

  int checks;
  int errors;
  int highs;

  match_event_counter #(.STRETCH_CYCLES(4), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .det_in(det_in),
    .count_ones(count_ones), .count_tens(count_tens), .hex0(hex0), .hex1(hex1),
    .hit_led(hit_led), .overflow(overflow)
  );

  match_event_counter #(.STRETCH_CYCLES(4), .WRAP(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .det_in(det_in),
    .count_ones(sat_ones), .count_tens(sat_tens), .hex0(sat_hex0), .hex1(sat_hex1),
    .hit_led(sat_hit_led), .overflow(sat_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the following falling edge.
  task automatic applyStimulus(input logic d, input logic e, input logic c);
    det_in = d;
    enable = e;
    clear  = c;
    @(negedge clk);
  endtask

  task automatic pulse(input logic e, input int lows);
    applyStimulus(1'b1, e, 1'b0);
    repeat (lows) applyStimulus(1'b0, e, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear  = 1'b0;
    enable = 1'b0;
    det_in = 1'b0;

    @(negedge clk);
    checkOutput("reset_ones", 32'(count_ones), 32'd0);
    checkOutput("reset_tens", 32'(count_tens), 32'd0);
    checkOutput("reset_hex0", 32'(hex0), 32'h40);
    checkOutput("reset_hex1", 32'(hex1), 32'h7F);
    checkOutput("reset_hit", 32'(hit_led), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);

    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] three single-cycle pulses");
    repeat (3) pulse(1'b1, 3);
    checkOutput("three_ones", 32'(count_ones), 32'd3);
    checkOutput("three_tens", 32'(count_tens), 32'd0);
    checkOutput("three_hex0", 32'(hex0), 32'h30);
    checkOutput("three_hex1", 32'(hex1), 32'h7F);

    $display("[TB] det_in held high for ten cycles");
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hold_pre_hit", 32'(hit_led), 32'd0);
    highs = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("hold_hit_c%0d", i), 32'(hit_led), (i <= 4) ? 32'd1 : 32'd0);
      if (hit_led === 1'b1) highs++;
    end
    checkOutput("hold_hit_total", 32'(highs), 32'd4);
    checkOutput("hold_ones", 32'(count_ones), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] run up to 99 and past it");
    repeat (95) pulse(1'b1, 1);
    checkOutput("at99_ones", 32'(count_ones), 32'd9);
    checkOutput("at99_tens", 32'(count_tens), 32'd9);
    checkOutput("at99_hex1", 32'(hex1), 32'h10);
    checkOutput("at99_ovf", 32'(overflow), 32'd0);
    checkOutput("at99_sat_ovf", 32'(sat_overflow), 32'd0);
    pulse(1'b1, 1);
    checkOutput("wrap_ones", 32'(count_ones), 32'd0);
    checkOutput("wrap_tens", 32'(count_tens), 32'd0);
    checkOutput("wrap_ovf", 32'(overflow), 32'd1);
    checkOutput("sat_ones", 32'(sat_ones), 32'd9);
    checkOutput("sat_tens", 32'(sat_tens), 32'd9);
    checkOutput("sat_ovf", 32'(sat_overflow), 32'd1);
    pulse(1'b1, 1);
    checkOutput("wrap_next_ones", 32'(count_ones), 32'd1);
    checkOutput("wrap_next_ovf", 32'(overflow), 32'd1);
    checkOutput("sat_next_ones", 32'(sat_ones), 32'd9);
    checkOutput("sat_next_tens", 32'(sat_tens), 32'd9);
    checkOutput("sat_next_ovf", 32'(sat_overflow), 32'd1);

    $display("[TB] clear, enable gating and clear against a rising det_in");
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("clr_ones", 32'(count_ones), 32'd0);
    checkOutput("clr_ovf", 32'(overflow), 32'd0);
    checkOutput("clr_sat_tens", 32'(sat_tens), 32'd0);
    checkOutput("clr_sat_ovf", 32'(sat_overflow), 32'd0);
    repeat (5) pulse(1'b0, 3);
    checkOutput("disabled_ones", 32'(count_ones), 32'd0);
    checkOutput("disabled_hit", 32'(hit_led), 32'd0);
    repeat (2) pulse(1'b1, 3);
    checkOutput("enabled_ones", 32'(count_ones), 32'd2);
    checkOutput("enabled_hit", 32'(hit_led), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clr_evt_ones", 32'(count_ones), 32'd0);
    checkOutput("clr_evt_ovf", 32'(overflow), 32'd0);
    checkOutput("clr_evt_hit", 32'(hit_led), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("clr_evt_later_ones", 32'(count_ones), 32'd0);
    checkOutput("clr_evt_later_hit", 32'(hit_led), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] stretch reload on events two cycles apart");
    repeat (10) pulse(1'b1, 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ten_tens", 32'(count_tens), 32'd1);
    checkOutput("ten_hit", 32'(hit_led), 32'd0);
    highs = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    if (hit_led === 1'b1) highs++;
    applyStimulus(1'b0, 1'b1, 1'b0);
    if (hit_led === 1'b1) highs++;
    applyStimulus(1'b1, 1'b1, 1'b0);
    if (hit_led === 1'b1) highs++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (hit_led === 1'b1) highs++;
    end
    checkOutput("reload_hit_total", 32'(highs), 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reload_hit_end", 32'(hit_led), 32'd0);
    checkOutput("twelve_ones", 32'(count_ones), 32'd2);
    checkOutput("twelve_tens", 32'(count_tens), 32'd1);
    checkOutput("twelve_hex1", 32'(hex1), 32'h79);
    checkOutput("twelve_hex0", 32'(hex0), 32'h24);

    $display("[TB] asynchronous reset mid-stretch at 47");
    repeat (35) pulse(1'b1, 1);
    checkOutput("at47_tens", 32'(count_tens), 32'd4);
    checkOutput("at47_ones", 32'(count_ones), 32'd7);
    checkOutput("at47_hit", 32'(hit_led), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_ones", 32'(count_ones), 32'd0);
    checkOutput("areset_tens", 32'(count_tens), 32'd0);
    checkOutput("areset_hex0", 32'(hex0), 32'h40);
    checkOutput("areset_hex1", 32'(hex1), 32'h7F);
    checkOutput("areset_hit", 32'(hit_led), 32'd0);
    checkOutput("areset_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
